// File: rtl/fpg8_ctrl_pkg.sv
// FPG8 control unit shared definitions: state encoding, opcodes, select/ALU codes
// and the control word driven by the decoder.
package fpg8_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F0   = 4'd1,
        S_F1   = 4'd2,
        S_F2   = 4'd3,
        S_F3   = 4'd4,
        S_DEC  = 4'd5,
        S_E0   = 4'd6,
        S_E1   = 4'd7,
        S_E2   = 4'd8,
        S_TRAP = 4'd9,
        S_HALT = 4'd10
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_MOV   = 4'h7;
    localparam logic [3:0] OP_BRZ   = 4'h8;
    localparam logic [3:0] OP_BRN   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] SEL_RD1 = 3'd0;
    localparam logic [2:0] SEL_RD2 = 3'd1;
    localparam logic [2:0] SEL_RS1 = 3'd2;
    localparam logic [2:0] SEL_RS2 = 3'd3;
    localparam logic [2:0] SEL_R7  = 3'd4;

    localparam logic [2:0] ALU_PASSY = 3'd0;
    localparam logic [2:0] ALU_ADD   = 3'd1;
    localparam logic [2:0] ALU_SUB   = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_INCY  = 3'd5;

    typedef struct packed {
        logic [2:0] alu;
        logic [2:0] gpr_sel;
        logic       gpr_in;
        logic       gpr_out;
        logic       ir_in;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       ram_rd;
        logic       ram_wr;
        logic       y_in;
        logic       y_out;
        logic       y_offset_in;
        logic       y_shl;
        logic       y_shr;
        logic       z_in;
        logic       z_out;
        logic       rom_out;
        logic       timer_in;
        logic       halted;
    } ctrl_t;

    // Opcodes 3..6 are the only ones that touch the ALU result flags.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_OR);
    endfunction

    function automatic logic [2:0] alu_for(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_PASSY;
        endcase
    endfunction

endpackage

// File: rtl/fpg8_ctrl_decode.sv
// Combinational control-word decode from (state, latched opcode, S, flags).
module fpg8_ctrl_decode
    import fpg8_ctrl_pkg::*;
#(
    parameter logic [2:0] PC_SEL = 3'd4
) (
    input  state_t     i_state,
    input  logic [3:0] i_opcode,
    input  logic       i_s,
    input  logic       i_flag_n,
    input  logic       i_flag_z,
    output ctrl_t      o_ctrl
);

    logic w_taken;
    assign w_taken = ((i_opcode == OP_BRZ) && i_flag_z) || ((i_opcode == OP_BRN) && i_flag_n);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_F0: begin
                o_ctrl.gpr_out = 1'b1; o_ctrl.gpr_sel = PC_SEL;
                o_ctrl.mar_in  = 1'b1; o_ctrl.y_in    = 1'b1;
            end
            S_F1: begin
                o_ctrl.ram_rd = 1'b1; o_ctrl.alu = ALU_INCY; o_ctrl.z_in = 1'b1;
            end
            S_F2: begin
                o_ctrl.z_out = 1'b1; o_ctrl.gpr_in = 1'b1; o_ctrl.gpr_sel = PC_SEL;
            end
            S_F3: begin
                o_ctrl.mdr_out = 1'b1; o_ctrl.ir_in = 1'b1;
            end
            S_E0: begin
                case (i_opcode)
                    OP_LOAD:  begin o_ctrl.gpr_out = 1'b1; o_ctrl.gpr_sel = SEL_RS1; o_ctrl.mar_in = 1'b1; end
                    OP_STORE: begin o_ctrl.gpr_out = 1'b1; o_ctrl.gpr_sel = SEL_RD1; o_ctrl.mar_in = 1'b1; end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_BRZ, OP_BRN: begin
                        o_ctrl.gpr_out = 1'b1; o_ctrl.gpr_sel = SEL_RS1; o_ctrl.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_E1: begin
                case (i_opcode)
                    OP_LOAD:  o_ctrl.ram_rd = 1'b1;
                    OP_STORE: begin o_ctrl.gpr_out = 1'b1; o_ctrl.gpr_sel = SEL_RS1; o_ctrl.mdr_in = 1'b1; end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        o_ctrl.gpr_out = 1'b1; o_ctrl.gpr_sel = SEL_RS2;
                        o_ctrl.alu     = alu_for(i_opcode);
                        o_ctrl.z_in    = 1'b1; o_ctrl.y_shl = i_s;
                    end
                    OP_MOV, OP_BRZ, OP_BRN: begin o_ctrl.alu = ALU_PASSY; o_ctrl.z_in = 1'b1; end
                    default: ;
                endcase
            end
            S_E2: begin
                case (i_opcode)
                    OP_LOAD:  begin o_ctrl.mdr_out = 1'b1; o_ctrl.gpr_in = 1'b1; o_ctrl.gpr_sel = SEL_RD1; end
                    OP_STORE: o_ctrl.ram_wr = 1'b1;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV: begin
                        o_ctrl.z_out = 1'b1; o_ctrl.gpr_in = 1'b1; o_ctrl.gpr_sel = SEL_RD1;
                    end
                    OP_BRZ, OP_BRN: begin
                        // Branch not taken leaves E2 as a dead cycle.
                        o_ctrl.z_out   = w_taken;
                        o_ctrl.gpr_in  = w_taken;
                        o_ctrl.gpr_sel = w_taken ? PC_SEL : SEL_RD1;
                    end
                    default: ;
                endcase
            end
            S_TRAP: begin
                o_ctrl.rom_out = 1'b1; o_ctrl.gpr_in = 1'b1;
                o_ctrl.gpr_sel = PC_SEL; o_ctrl.timer_in = 1'b1;
            end
            S_HALT: o_ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/fpg8_control_unit.sv
// FPG8 hardwired micro-sequencer: state register, flags, opcode latch and trap
// bookkeeping; strobes come from the combinational decoder.
module fpg8_control_unit
    import fpg8_ctrl_pkg::*;
#(
    parameter logic [2:0] PC_SEL      = 3'd4,
    parameter bit         TRAP_ENABLE = 1'b1
) (
    input  logic       one_shot_clock,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       S,
    input  logic       CC_N,
    input  logic       CC_Z,
    input  logic       timeout,
    output logic [2:0] ALU_control,
    output logic       GPR_in,
    output logic       GPR_out,
    output logic [2:0] GPR_select,
    output logic       IR_in,
    output logic       MAR_in,
    output logic       MDR_in,
    output logic       MDR_out,
    output logic       RAM_enable_read,
    output logic       RAM_enable_write,
    output logic       Y_in,
    output logic       Y_out,
    output logic       Y_offset_in,
    output logic       Y_shift_left,
    output logic       Y_shift_right,
    output logic       Z_in,
    output logic       Z_out,
    output logic       con_ROM_out,
    output logic       timer_in,
    output logic       halted,
    output logic [3:0] state_dbg
);

    state_t     r_state, w_next;
    logic [3:0] r_opcode;
    logic       r_flag_n, r_flag_z, r_trap_pending;
    ctrl_t      w_ctrl;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_E2: w_next = r_trap_pending ? S_TRAP : S_F0;
            S_F0:         w_next = S_F1;
            S_F1:         w_next = S_F2;
            S_F2:         w_next = S_F3;
            S_F3:         w_next = S_DEC;
            S_DEC:        w_next = (opcode == OP_HALT) ? S_HALT : S_E0;
            S_E0:         w_next = S_E1;
            S_E1:         w_next = S_E2;
            S_TRAP:       w_next = S_F0;
            S_HALT:       w_next = S_HALT;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge one_shot_clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_opcode       <= OP_NOP;
            r_flag_n       <= 1'b0;
            r_flag_z       <= 1'b0;
            r_trap_pending <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DEC)
                r_opcode <= opcode;
            if ((r_state == S_E1) && is_alu_op(r_opcode)) begin
                r_flag_n <= CC_N;
                r_flag_z <= CC_Z;
            end
            // Entering or sitting in HALT discards any trap; TRAP consumes it.
            if ((r_state == S_TRAP) || (w_next == S_HALT))
                r_trap_pending <= 1'b0;
            else if (timeout && TRAP_ENABLE)
                r_trap_pending <= 1'b1;
        end
    end

    fpg8_ctrl_decode #(.PC_SEL(PC_SEL)) u_decode (
        .i_state  (r_state),
        .i_opcode (r_opcode),
        .i_s      (S),
        .i_flag_n (r_flag_n),
        .i_flag_z (r_flag_z),
        .o_ctrl   (w_ctrl)
    );

    assign ALU_control      = w_ctrl.alu;
    assign GPR_in           = w_ctrl.gpr_in;
    assign GPR_out          = w_ctrl.gpr_out;
    assign GPR_select       = w_ctrl.gpr_sel;
    assign IR_in            = w_ctrl.ir_in;
    assign MAR_in           = w_ctrl.mar_in;
    assign MDR_in           = w_ctrl.mdr_in;
    assign MDR_out          = w_ctrl.mdr_out;
    assign RAM_enable_read  = w_ctrl.ram_rd;
    assign RAM_enable_write = w_ctrl.ram_wr;
    assign Y_in             = w_ctrl.y_in;
    assign Y_out            = w_ctrl.y_out;
    assign Y_offset_in      = w_ctrl.y_offset_in;
    assign Y_shift_left     = w_ctrl.y_shl;
    assign Y_shift_right    = w_ctrl.y_shr;
    assign Z_in             = w_ctrl.z_in;
    assign Z_out            = w_ctrl.z_out;
    assign con_ROM_out      = w_ctrl.rom_out;
    assign timer_in         = w_ctrl.timer_in;
    assign halted           = w_ctrl.halted;
    assign state_dbg        = r_state;

endmodule

// File: tb/tb_fpg8_control_unit.sv
// Randomized bench for fpg8_control_unit against a queue-based schedule model.
module tb_fpg8_control_unit;
    import fpg8_ctrl_pkg::*;

    logic one_shot_clock = 1'b0;
    logic reset = 1'b1, S = 1'b0, CC_N = 1'b0, CC_Z = 1'b0, timeout = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic [2:0] ALU_control, GPR_select;
    logic GPR_in, GPR_out, IR_in, MAR_in, MDR_in, MDR_out, RAM_enable_read, RAM_enable_write;
    logic Y_in, Y_out, Y_offset_in, Y_shift_left, Y_shift_right, Z_in, Z_out;
    logic con_ROM_out, timer_in, halted;
    logic [3:0] state_dbg;

    fpg8_control_unit dut (
        .one_shot_clock(one_shot_clock), .reset(reset), .opcode(opcode), .S(S),
        .CC_N(CC_N), .CC_Z(CC_Z), .timeout(timeout),
        .ALU_control(ALU_control), .GPR_in(GPR_in), .GPR_out(GPR_out), .GPR_select(GPR_select),
        .IR_in(IR_in), .MAR_in(MAR_in), .MDR_in(MDR_in), .MDR_out(MDR_out),
        .RAM_enable_read(RAM_enable_read), .RAM_enable_write(RAM_enable_write),
        .Y_in(Y_in), .Y_out(Y_out), .Y_offset_in(Y_offset_in),
        .Y_shift_left(Y_shift_left), .Y_shift_right(Y_shift_right),
        .Z_in(Z_in), .Z_out(Z_out), .con_ROM_out(con_ROM_out), .timer_in(timer_in),
        .halted(halted), .state_dbg(state_dbg)
    );

    always #5 one_shot_clock = ~one_shot_clock;

    // Strobe bit positions in the 17-bit strobe field.
    localparam logic [16:0] GIN = 17'h10000, GOUT = 17'h08000, IRIN = 17'h04000, MARIN = 17'h02000;
    localparam logic [16:0] MDRIN = 17'h01000, MDROUT = 17'h00800, RD = 17'h00400, WR = 17'h00200;
    localparam logic [16:0] YIN = 17'h00100, YSL = 17'h00020, ZIN = 17'h00008, ZOUT = 17'h00004;
    localparam logic [16:0] ROM = 17'h00002, TMR = 17'h00001;
    localparam int A_NONE = 0, A_DEC = 1, A_FLAG = 2, A_TRAP = 3, A_HALT = 4;

    int n_vec = 0, n_err = 0, cyc = 0, halt_cnt = 0;
    logic [27:0] exp_q[$];
    int          act_q[$];
    logic        m_fn, m_fz, m_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [27:0] mk(input logic [3:0] st, input logic [2:0] alu,
                                       input logic [2:0] sel, input logic [16:0] s, input logic h);
        return {st, alu, sel, h, s};
    endfunction

    function automatic logic [27:0] observed();
        return {state_dbg, ALU_control, GPR_select, halted, GPR_in, GPR_out, IR_in, MAR_in,
                MDR_in, MDR_out, RAM_enable_read, RAM_enable_write, Y_in, Y_out, Y_offset_in,
                Y_shift_left, Y_shift_right, Z_in, Z_out, con_ROM_out, timer_in};
    endfunction

    task automatic push(input logic [27:0] w, input int a);
        exp_q.push_back(w);
        act_q.push_back(a);
    endtask

    task automatic model_reset();
        exp_q.delete(); act_q.delete();
        m_fn = 1'b0; m_fz = 1'b0; m_pend = 1'b0;
        push(mk(S_IDLE, 3'd0, 3'd0, 17'h0, 1'b0), A_NONE);
    endtask

    // Execute schedule for one instruction, decided at decode time.
    task automatic push_exec(input logic [3:0] op, input logic s);
        logic tk;
        tk = (op == 4'h8 && m_fz) || (op == 4'h9 && m_fn);
        case (op)
            4'h1: begin
                push(mk(S_E0, 0, 2, GOUT | MARIN, 0), A_NONE);
                push(mk(S_E1, 0, 0, RD, 0), A_NONE);
                push(mk(S_E2, 0, 0, MDROUT | GIN, 0), A_NONE);
            end
            4'h2: begin
                push(mk(S_E0, 0, 0, GOUT | MARIN, 0), A_NONE);
                push(mk(S_E1, 0, 2, GOUT | MDRIN, 0), A_NONE);
                push(mk(S_E2, 0, 0, WR, 0), A_NONE);
            end
            4'h3, 4'h4, 4'h5, 4'h6: begin
                push(mk(S_E0, 0, 2, GOUT | YIN, 0), A_NONE);
                push(mk(S_E1, 3'(op - 4'd2), 3, GOUT | ZIN | (s ? YSL : 17'h0), 0), A_FLAG);
                push(mk(S_E2, 0, 0, ZOUT | GIN, 0), A_NONE);
            end
            4'h7, 4'h8, 4'h9: begin
                push(mk(S_E0, 0, 2, GOUT | YIN, 0), A_NONE);
                push(mk(S_E1, 0, 0, ZIN, 0), A_NONE);
                if (op == 4'h7 || tk) push(mk(S_E2, 0, (op == 4'h7) ? 3'd0 : 3'd4, ZOUT | GIN, 0), A_NONE);
                else                  push(mk(S_E2, 0, 0, 17'h0, 0), A_NONE);
            end
            default: begin
                push(mk(S_E0, 0, 0, 17'h0, 0), A_NONE);
                push(mk(S_E1, 0, 0, 17'h0, 0), A_NONE);
                push(mk(S_E2, 0, 0, 17'h0, 0), A_NONE);
            end
        endcase
    endtask

    // Advance the model across one rising edge using the inputs present at it.
    task automatic model_edge();
        int  a;
        logic old_pend;
        if (reset) begin model_reset(); return; end
        void'(exp_q.pop_front());
        a = act_q.pop_front();
        old_pend = m_pend;
        if (a == A_TRAP) m_pend = 1'b0;
        else if (timeout) m_pend = 1'b1;
        case (a)
            A_DEC: begin
                if (opcode == 4'hF) begin
                    push(mk(S_HALT, 0, 0, 17'h0, 1), A_HALT);
                    m_pend = 1'b0;
                end else push_exec(opcode, S);
            end
            A_FLAG: begin m_fn = CC_N; m_fz = CC_Z; end
            A_HALT: begin push(mk(S_HALT, 0, 0, 17'h0, 1), A_HALT); m_pend = 1'b0; end
            default: ;
        endcase
        if (exp_q.size() == 0) begin
            if (old_pend) push(mk(S_TRAP, 0, 4, ROM | GIN | TMR, 0), A_TRAP);
            push(mk(S_F0, 0, 4, GOUT | MARIN | YIN, 0), A_NONE);
            push(mk(S_F1, 5, 0, RD | ZIN, 0), A_NONE);
            push(mk(S_F2, 0, 4, ZOUT | GIN, 0), A_NONE);
            push(mk(S_F3, 0, 0, MDROUT | IRIN, 0), A_NONE);
            push(mk(S_DEC, 0, 0, 17'h0, 0), A_DEC);
        end
    endtask

    initial begin
        logic [3:0] op;
        reset = 1'b1;
        repeat (2) @(posedge one_shot_clock);
        #1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc = i;
            // Drive inputs just after the active edge.
            reset   = (i > 0) && ((halt_cnt > 4) || ($urandom_range(0, 99) == 0));
            timeout = ($urandom_range(0, 19) == 0);
            CC_N    = 1'($urandom);
            CC_Z    = 1'($urandom);
            op      = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h3;
            opcode  = op;
            if (act_q.size() > 0 && act_q[0] == A_DEC) S = 1'($urandom);
            #5;
            if (exp_q.size() == 0) chk("model_empty", 32'd1, 32'd0);
            else begin
                chk("ctl", {4'h0, observed()}, {4'h0, exp_q[0]});
                halt_cnt = exp_q[0][17] ? halt_cnt + 1 : 0;
            end
            chk("bus_excl", 32'($countones({GPR_out, MDR_out, Z_out, Y_out, con_ROM_out}) <= 1), 32'd1);
            @(posedge one_shot_clock);
            model_edge();
            #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpg8_control_unit.md
Name: fpg8_control_unit

Overview:
- Hardwired micro-sequencer that drives every datapath control strobe of the FPG8 core: GPR, IR, MAR, MDR, RAM, Y, Z, shifter, ALU, constant ROM and timer.
- Fetches the word at PC (GPR R7), latches it into IR, decodes `opcode`, then runs a fixed 3-cycle execute sequence.
- Keeps its own N/Z condition flags, latched from the comparator.
- Vectors to address 8 when the timer raises `timeout`.

Parameters:
- PC_SEL, 3'd4, GPR_select code addressing R7 (PC).
- TRAP_ENABLE, 1, 1 = `timeout` forces trap entry at the next fetch boundary; 0 = `timeout` ignored.

Ports:
- one_shot_clock  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  4  from IR.
- S  in  1  from IR; 1 = shift Y on the ALU step.
- CC_N  in  1  comparator negative bit.
- CC_Z  in  1  comparator zero bit.
- timeout  in  1  from timer.
- ALU_control  out  3  ALU function select.
- GPR_in, GPR_out  out  1 each  GPR load / drive bus.
- GPR_select  out  3  register select: 0=Rd_1, 1=Rd_2, 2=Rs_1, 3=Rs_2, 4=R7.
- IR_in, MAR_in, MDR_in, MDR_out  out  1 each  register strobes.
- RAM_enable_read, RAM_enable_write  out  1 each  RAM strobes.
- Y_in, Y_out, Y_offset_in, Y_shift_left, Y_shift_right  out  1 each  Y and shifter strobes.
- Z_in, Z_out  out  1 each  Z strobes.
- con_ROM_out, timer_in  out  1 each  constant ROM drive; timer load.
- halted  out  1  1 while in the HALT state.
- state_dbg  out  4  current state encoding.

Behaviour:
- Outputs are a combinational decode of (state, latched opcode, S, flags).
- Every strobe is valid during the cycle in which its state is held.
- Reset: state <= S_IDLE, N/Z flags <= 0, latched opcode <= 0, trap_pending <= 0.
- In S_IDLE all outputs are 0 (ALU_control=0, GPR_select=0) and halted=0.
- Reset asserted in any state, including mid-instruction, aborts the instruction on that edge. No partial write completes after the edge.
- Bus exclusivity: at most one of GPR_out, MDR_out, Z_out, Y_out, con_ROM_out is high in any state.
- ALU_control codes: 0 PASSY, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 INCY.
- Sequence: S_IDLE -> S_F0 on the next clock, then F0 -> F1 -> F2 -> F3 -> S_DEC -> E0 -> E1 -> E2 -> F0.
- Fetch is 4 cycles, decode 1, execute 3: every instruction takes 8 cycles.
- F0: GPR_out, GPR_select=PC_SEL, MAR_in, Y_in.
- F1: RAM_enable_read, ALU_control=INCY, Z_in.
- F2: Z_out, GPR_in, GPR_select=PC_SEL.
- F3: MDR_out, IR_in.
- DEC: no strobes; registers `opcode` internally.
- Execute steps per opcode:
  - 1 LOAD: E0 GPR_out Rs_1 + MAR_in; E1 RAM_enable_read; E2 MDR_out + GPR_in Rd_1.
  - 2 STORE: E0 GPR_out Rd_1 + MAR_in; E1 GPR_out Rs_1 + MDR_in; E2 RAM_enable_write.
  - 3 ADD, 4 SUB, 5 AND, 6 OR: E0 GPR_out Rs_1 + Y_in; E1 GPR_out Rs_2 + ALU op + Z_in, with Y_shift_left = S; E2 Z_out + GPR_in Rd_1.
  - 7 MOV: E0 GPR_out Rs_1 + Y_in; E1 ALU PASSY + Z_in; E2 Z_out + GPR_in Rd_1.
  - 8 BRZ, 9 BRN: same steps as MOV. E2 writes PC (select 4) only if flag Z (BRZ) or flag N (BRN) is set; otherwise E2 is an empty cycle.
  - 0 NOP and undefined opcodes: E0–E2 empty.
  - F HALT: DEC -> S_HALT. S_HALT holds all strobes 0 with halted=1 until reset.
- Flags: latched from CC_N/CC_Z at the end of E1 for opcodes 3–6 only. All other opcodes leave the flags unchanged.
- Trap: trap_pending sets when `timeout` is high at any edge and TRAP_ENABLE=1.
  - Trap is taken only at the F0 boundary: at the E2 -> F0 or IDLE -> F0 transition, go to S_TRAP instead of F0.
  - S_TRAP (1 cycle): con_ROM_out, GPR_in select PC (PC <= 8), timer_in (timer reloads 8, clearing timeout). trap_pending <= 0, then -> F0.
  - An instruction in flight always completes before the trap is taken.
  - If `timeout` and HALT coincide, HALT wins and the trap is discarded.

Decomposition:
- Package fpg8_ctrl_pkg holds:
  - opcode localparams;
  - state encoding (IDLE, F0–F3, DEC, E0–E2, TRAP, HALT);
  - GPR_select codes;
  - ALU_control codes.
- Sub-module fpg8_ctrl_decode: purely combinational mapping of (state, opcode, S, flags) to the control word.
- The top of the block holds the state register, flags, opcode latch and trap_pending.

Test Plan:
- Reset, then 1 clock -> state_dbg = F0; F0 asserts GPR_out, MAR_in, Y_in with GPR_select=4; all other strobes 0.
- opcode=3 (ADD), S=0, CC_Z=1 at E1 -> E1 asserts ALU_control=1, Z_in, GPR_select=3; flag Z=1; next instruction starts at F0 8 cycles after the previous F0.
- opcode=8 (BRZ) after that ADD -> E2 asserts Z_out, GPR_in, GPR_select=4. Repeat with flag Z=0 -> E2 all strobes 0.
- opcode=2 (STORE) -> RAM_enable_write high exactly in E2, MDR_in only in E1; bus-exclusivity assertion holds on every cycle.
- timeout pulsed during E1 of an ADD -> E2 completes normally, then S_TRAP asserts con_ROM_out, GPR_in select 4, timer_in; next state F0.
- opcode=F -> halted=1 indefinitely. Reset asserted mid-E1 of a LOAD -> S_IDLE next edge, all outputs 0, flags 0.
